// File: rtl/regdst_pipe.sv
// regdst_pipe
//   Selects a destination register index from NUM_SRC packed candidate
//   fields and carries it through a DEPTH-stage shift pipeline to the
//   write-back point. Every in-flight destination is visible to two
//   combinational RAW-hazard comparators used by the control unit.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   sel        candidate select
//   data_in    packed candidates, candidate i = data_in[i*DATA_W +: DATA_W]
//   in_valid   a destination is offered this cycle
//   stall      holds every stage (offered entry is dropped)
//   flush      invalidates every in-flight entry
//   query_a/b  source indices checked against in-flight destinations
//   dst_out    destination index at the tail stage
//   dst_valid  tail stage holds a valid write
//   hazard_a/b query matches a valid in-flight destination (0 for index 0)
//   occupancy  number of valid stages
//   sel_err    one-cycle pulse: out-of-range select offered with in_valid
module regdst_pipe #(
  parameter int NUM_SRC     = 4,
  parameter int SEL_W       = 2,
  parameter int DATA_W      = 5,
  parameter int DEPTH       = 3,
  parameter int ZERO_SQUASH = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [SEL_W-1:0]             sel,
  input  logic [NUM_SRC*DATA_W-1:0]    data_in,
  input  logic                         in_valid,
  input  logic                         stall,
  input  logic                         flush,
  input  logic [DATA_W-1:0]            query_a,
  input  logic [DATA_W-1:0]            query_b,
  output logic [DATA_W-1:0]            dst_out,
  output logic                         dst_valid,
  output logic                         hazard_a,
  output logic                         hazard_b,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic                         sel_err
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0]  vld_p;
  logic [DATA_W-1:0] idx_p [DEPTH];

  logic [DATA_W-1:0] selected_p0;
  logic              sel_ok_p0;
  logic              entry_vld_p0;
  logic              sel_bad_p0;
  logic [DEPTH-1:0]  vld_nxt;

  // Number of set bits in a stage-valid vector.
  function automatic logic [OCC_W-1:0] popcount(input logic [DEPTH-1:0] vec);
    logic [OCC_W-1:0] n;
    n = '0;
    for (int i = 0; i < DEPTH; i++) begin
      n = n + OCC_W'(vec[i]);
    end
    return n;
  endfunction

  // Any valid stage holding index q; index 0 is never a real dependency.
  function automatic logic stage_hit(input logic [DATA_W-1:0] q,
                                     input logic [DEPTH-1:0]  v,
                                     input logic [DATA_W-1:0] ix [DEPTH]);
    logic h;
    h = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (v[i] && (ix[i] == q)) h = 1'b1;
    end
    if (q == '0) h = 1'b0;
    return h;
  endfunction

  // ---- stage 0 entry: candidate select and validity ----
  always_comb begin
    selected_p0 = '0;
    sel_ok_p0   = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (sel == SEL_W'(i)) begin
        selected_p0 = data_in[i*DATA_W +: DATA_W];
        sel_ok_p0   = 1'b1;
      end
    end
  end

  // Out-of-range selects are reported but never enter the pipeline; when
  // NUM_SRC fills the selector space sel_ok_p0 is always 1 and this folds away.
  assign sel_bad_p0   = in_valid && !sel_ok_p0;
  assign entry_vld_p0 = in_valid && sel_ok_p0 &&
                        !((ZERO_SQUASH != 0) && (selected_p0 == '0));

  // Valid vector after a shift, used for both the stage update and occupancy
  // so the count always matches the registered stages.
  always_comb begin
    vld_nxt    = '0;
    vld_nxt[0] = entry_vld_p0;
    for (int i = 1; i < DEPTH; i++) begin
      vld_nxt[i] = vld_p[i-1];
    end
  end

  // ---- stages 0..DEPTH-1: shift register toward write-back ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p     <= '0;
      for (int i = 0; i < DEPTH; i++) idx_p[i] <= '0;
      occupancy <= '0;
      sel_err   <= 1'b0;
    end else if (flush) begin
      vld_p     <= '0;
      occupancy <= '0;
      sel_err   <= 1'b0;
    end else begin
      // Error flag is sampled even on stalled edges.
      sel_err <= sel_bad_p0;
      if (!stall) begin
        vld_p    <= vld_nxt;
        idx_p[0] <= selected_p0;
        for (int i = 1; i < DEPTH; i++) idx_p[i] <= idx_p[i-1];
        occupancy <= popcount(vld_nxt);
      end
    end
  end

  // ---- tail: write-back view and hazard comparators ----
  assign dst_out   = idx_p[DEPTH-1];
  assign dst_valid = vld_p[DEPTH-1];

  // Tail stage is included: its write lands only at the edge that retires it.
  always_comb begin
    hazard_a = stage_hit(query_a, vld_p, idx_p);
    hazard_b = stage_hit(query_b, vld_p, idx_p);
  end

endmodule

// File: tb/tb_regdst_pipe.sv
module tb_regdst_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic        rst0;
  logic [1:0]  sel0;
  logic [19:0] din0;
  logic        iv0, st0, fl0;
  logic [4:0]  qa0, qb0;
  logic [4:0]  dout0;
  logic        dv0, ha0, hb0, se0;
  logic [1:0]  occ0;

  // NUM_SRC=3, DEPTH=4 instance
  logic        rst1;
  logic [1:0]  sel1;
  logic [14:0] din1;
  logic        iv1, st1, fl1;
  logic [4:0]  qa1, qb1;
  logic [4:0]  dout1;
  logic        dv1, ha1, hb1, se1;
  logic [2:0]  occ1;

  regdst_pipe u_dut0 (
    .clk(clk), .reset(rst0), .sel(sel0), .data_in(din0), .in_valid(iv0),
    .stall(st0), .flush(fl0), .query_a(qa0), .query_b(qb0),
    .dst_out(dout0), .dst_valid(dv0), .hazard_a(ha0), .hazard_b(hb0),
    .occupancy(occ0), .sel_err(se0)
  );

  regdst_pipe #(.NUM_SRC(3), .SEL_W(2), .DATA_W(5), .DEPTH(4), .ZERO_SQUASH(1)) u_dut1 (
    .clk(clk), .reset(rst1), .sel(sel1), .data_in(din1), .in_valid(iv1),
    .stall(st1), .flush(fl1), .query_a(qa1), .query_b(qb1),
    .dst_out(dout1), .dst_valid(dv1), .hazard_a(ha1), .hazard_b(hb1),
    .occupancy(occ1), .sel_err(se1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst0 = 1'b0; sel0 = '0; din0 = '0; iv0 = 1'b0; st0 = 1'b0; fl0 = 1'b0; qa0 = 5'd5; qb0 = '0;
    rst1 = 1'b0; sel1 = '0; din1 = '0; iv1 = 1'b0; st1 = 1'b0; fl1 = 1'b0; qa1 = '0;   qb1 = '0;
    tick(); tick();
    chk("rst_dout", 32'(dout0), 0);
    chk("rst_dv",   32'(dv0),   0);
    chk("rst_occ",  32'(occ0),  0);
    chk("rst_ha",   32'(ha0),   0);
    chk("rst_se",   32'(se0),   0);
    rst0 = 1'b1; rst1 = 1'b1;
    tick();

    // Latency: candidate 1 = 17 accepted at edge 0, at tail after edge 2.
    din0 = {5'd31, 5'd8, 5'd17, 5'd9};
    sel0 = 2'd1; iv0 = 1'b1; qa0 = 5'd17;
    #1;
    chk("lat_ha_pre", 32'(ha0), 0);
    tick(); iv0 = 1'b0;                    // edge 0
    chk("lat_dv_e0",  32'(dv0),  0);
    chk("lat_occ_e0", 32'(occ0), 1);
    chk("lat_ha_e0",  32'(ha0),  1);
    tick();                                // edge 1
    chk("lat_dv_e1",  32'(dv0),  0);
    chk("lat_ha_e1",  32'(ha0),  1);
    tick();                                // edge 2
    chk("lat_dv_e2",   32'(dv0),   1);
    chk("lat_dout_e2", 32'(dout0), 17);
    chk("lat_ha_e2",   32'(ha0),   1);
    tick();                                // edge 3
    chk("lat_dv_e3",  32'(dv0),  0);
    chk("lat_ha_e3",  32'(ha0),  0);
    chk("lat_occ_e3", 32'(occ0), 0);

    // Zero squash: candidate 2 holds index 0.
    din0 = {5'd31, 5'd0, 5'd17, 5'd9};
    sel0 = 2'd2; iv0 = 1'b1; qb0 = 5'd0;
    tick(); iv0 = 1'b0;
    chk("zs_occ", 32'(occ0), 0);
    chk("zs_hb",  32'(hb0),  0);
    for (int k = 0; k < 3; k++) begin
      chk("zs_dv", 32'(dv0), 0);
      tick();
    end

    // Stall/flush: 4, 5, 6 back-to-back.
    din0 = {5'd31, 5'd6, 5'd5, 5'd4};
    iv0 = 1'b1; sel0 = 2'd0; tick();
    sel0 = 2'd1; tick();
    sel0 = 2'd2; tick();
    chk("sf_dout_e2", 32'(dout0), 4);
    chk("sf_occ_e2",  32'(occ0),  3);
    // Offered entry (31) during stall must be dropped.
    st0 = 1'b1; sel0 = 2'd3; qb0 = 5'd31;
    tick();
    chk("sf_dout_s1", 32'(dout0), 4);
    chk("sf_dv_s1",   32'(dv0),   1);
    tick();
    chk("sf_dout_s2", 32'(dout0), 4);
    chk("sf_occ_s2",  32'(occ0),  3);
    st0 = 1'b0; iv0 = 1'b0;
    tick();
    chk("sf_dout_rel", 32'(dout0), 5);
    chk("sf_occ_rel",  32'(occ0),  2);
    chk("sf_hb_drop",  32'(hb0),   0);
    fl0 = 1'b1; iv0 = 1'b1; sel0 = 2'd0;
    tick();
    fl0 = 1'b0; iv0 = 1'b0;
    chk("fl_occ", 32'(occ0), 0);
    for (int k = 0; k < 3; k++) begin
      chk("fl_dv", 32'(dv0), 0);
      tick();
    end

    // Flush together with stall still clears.
    iv0 = 1'b1; sel0 = 2'd1; tick(); iv0 = 1'b0;
    chk("fs_occ_pre", 32'(occ0), 1);
    st0 = 1'b1; fl0 = 1'b1; tick(); st0 = 1'b0; fl0 = 1'b0;
    chk("fs_occ", 32'(occ0), 0);

    // Asynchronous reset mid-stream with 17 at tail and 9 at stage 0.
    din0 = {5'd31, 5'd8, 5'd17, 5'd9};
    qa0 = 5'd17;
    iv0 = 1'b1; sel0 = 2'd1; tick();
    iv0 = 1'b0; tick();
    iv0 = 1'b1; sel0 = 2'd0; tick();
    iv0 = 1'b0;
    chk("ar_occ_pre", 32'(occ0), 2);
    chk("ar_dv_pre",  32'(dv0),  1);
    chk("ar_ha_pre",  32'(ha0),  1);
    #2; rst0 = 1'b0; #1;
    chk("ar_dv",   32'(dv0),   0);
    chk("ar_occ",  32'(occ0),  0);
    chk("ar_ha",   32'(ha0),   0);
    chk("ar_dout", 32'(dout0), 0);
    tick(); rst0 = 1'b1;

    // Bad select on NUM_SRC=3.
    din1 = {5'd3, 5'd2, 5'd7};
    qa1 = 5'd7;
    iv1 = 1'b1; sel1 = 2'd0; tick();
    chk("bs_occ_pre", 32'(occ1), 1);
    chk("bs_se_pre",  32'(se1),  0);
    sel1 = 2'd3; tick();
    chk("bs_se",  32'(se1),  1);
    chk("bs_occ", 32'(occ1), 1);
    chk("bs_ha",  32'(ha1),  1);
    iv1 = 1'b0; tick();
    chk("bs_se_clr", 32'(se1),  0);
    chk("bs_occ2",   32'(occ1), 1);
    st1 = 1'b1; iv1 = 1'b1; tick();
    chk("bs_se_stall", 32'(se1), 1);
    st1 = 1'b0; iv1 = 1'b0; fl1 = 1'b1; tick(); fl1 = 1'b0;
    chk("bs_fl_occ", 32'(occ1), 0);

    // Full pipeline DEPTH=4, indices 1..10 continuous.
    sel1 = 2'd0;
    for (int n = 1; n <= 13; n++) begin
      int lo, hi, eocc;
      if (n <= 10) begin
        iv1 = 1'b1; din1 = {5'd0, 5'd0, 5'(n)};
      end else begin
        iv1 = 1'b0;
      end
      tick();
      lo   = (n - 3 < 1) ? 1 : n - 3;
      hi   = (n < 10) ? n : 10;
      eocc = (hi >= lo) ? hi - lo + 1 : 0;
      chk("fp_occ", 32'(occ1), 32'(eocc));
      if (n >= 4) begin
        chk("fp_dv",   32'(dv1),   1);
        chk("fp_dout", 32'(dout1), 32'(n - 3));
      end else begin
        chk("fp_dv0", 32'(dv1), 0);
      end
    end
    iv1 = 1'b0; tick();
    chk("fp_dv_end",  32'(dv1),  0);
    chk("fp_occ_end", 32'(occ1), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regdst_pipe.md
# regdst_pipe

Parametrised successor to the fixed 4:1 register-destination select. Picks a destination register index from `NUM_SRC` candidate fields, then carries it through a `DEPTH`-stage shift pipeline to the write-back point. It tracks every in-flight destination and gives the control unit combinational RAW-hazard flags for two source-register queries. The block sits between decode/control and register-bank write-back in the multicycle datapath.

## Interface
Parameters:
- `NUM_SRC`, 4: number of candidate destination fields (2..16).
- `SEL_W`, 2: selector width; must satisfy 2^SEL_W ≥ NUM_SRC.
- `DATA_W`, 5: register-index width.
- `DEPTH`, 3: pipeline stages from select to write-back (1..8).
- `ZERO_SQUASH`, 1: when 1, a selected index of 0 produces an invalid (bubble) entry.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `sel`  in  SEL_W  candidate select.
- `data_in`  in  NUM_SRC*DATA_W  packed candidates; candidate i is `data_in[i*DATA_W +: DATA_W]`.
- `in_valid`  in  1  a destination is offered this cycle.
- `stall`  in  1  holds all stages.
- `flush`  in  1  kills all in-flight entries.
- `query_a`, `query_b`  in  DATA_W  source indices to check against in-flight destinations.
- `dst_out`  out  DATA_W  destination index at the tail stage.
- `dst_valid`  out  1  the tail stage holds a valid write.
- `hazard_a`, `hazard_b`  out  1  the query matches a valid in-flight destination.
- `occupancy`  out  $clog2(DEPTH+1)  number of valid stages.
- `sel_err`  out  1  registered one-cycle pulse; `sel` ≥ NUM_SRC was presented with `in_valid`.

## Operation
- State: stage arrays `v[0..DEPTH-1]` and `idx[0..DEPTH-1]`, an `occupancy` register, and a `sel_err` register.
- Selected value: `data_in` slice `sel` when `sel` < NUM_SRC, else 0.
- Stage-0 entry: `v = in_valid && sel < NUM_SRC && !(ZERO_SQUASH && selected == 0)`; `idx = selected`.
- Edge priority, highest first:
  - `flush`: all `v` ← 0 and `occupancy` ← 0; `idx` is don't-care.
  - `stall`: all stages hold; `in_valid` is ignored and the offered entry is lost. Upstream must hold its request for the cycle after stall deasserts.
  - Otherwise: shift `stage[i]` ← `stage[i-1]` and load stage 0 with the new entry. `occupancy` ← popcount of the new `v` vector.
- `dst_out` = `idx[DEPTH-1]` and `dst_valid` = `v[DEPTH-1]`, both driven directly from registers.
- Hazards are combinational. `hazard_a` = OR over all i of (`v[i]` && `idx[i]` == `query_a`), masked to 0 when `query_a` == 0. `hazard_b` is defined the same way on `query_b`. The tail stage is included, because write-back has not completed until the edge it occupies.
- `sel_err` is set on any non-flush edge where `in_valid` is high and `sel` ≥ NUM_SRC, including stalled edges, and clears on the next edge. When NUM_SRC == 2^SEL_W the flag is structurally 0.

## Timing
- Reset (asynchronous, active-low): all `v` = 0, all `idx` = 0, `occupancy` = 0, `sel_err` = 0. As a result `dst_out` = 0, `dst_valid` = 0, and both hazard flags = 0.
- Latency: an entry accepted at edge k appears at `dst_out`/`dst_valid` after edge k+DEPTH-1, provided no stalls occur. Each stalled edge adds one cycle.
- Throughput: one entry per unstalled cycle. There is no backpressure output.
- Simultaneous events:
  - `flush` together with `in_valid` drops the new entry.
  - `flush` together with `stall` still clears the pipeline.
  - Reset asserted mid-operation clears state immediately, without waiting for a clock edge.
- Occupancy boundaries:
  - All stages valid: `occupancy` = DEPTH, with no overflow. The tail entry retires on the same edge a new one enters.
  - Pipeline empty: `occupancy` = 0 and the hazard flags are 0.
- Hazard flags settle in the same cycle a query changes, or after the edge that changes the stages.

## Test plan
- Reset: drive `reset` = 0 mid-stream with `occupancy` = 2 → `dst_valid` = 0, `occupancy` = 0, and `hazard_a` = 0 before the next edge.
- Latency, using defaults: `data_in` = {5'd31, 5'd8, 5'd17, 5'd9}, `sel` = 1, `in_valid` pulsed at edge 0 → `dst_out` = 17 and `dst_valid` = 1 after edge 2 only. `query_a` = 17 gives `hazard_a` = 1 from edge 0 through edge 2 inclusive.
- Zero squash: `sel` selects 5'd0 with `in_valid` = 1 → `occupancy` stays 0 and `dst_valid` never rises. `query_b` = 0 gives `hazard_b` = 0.
- Stall/flush: with indices 4, 5, 6 back-to-back, assert `stall` for 2 cycles → `dst_out` = 4 is held for 3 cycles. Then assert `flush` with `in_valid` = 1 → `occupancy` = 0 on the next edge and no further `dst_valid` pulses.
- Bad select: `NUM_SRC` = 3, `SEL_W` = 2, `sel` = 3, `in_valid` = 1 → `sel_err` = 1 for exactly one cycle and `occupancy` is unchanged.
- Full pipeline: `DEPTH` = 4 with continuous `in_valid` on indices 1..10 → `occupancy` saturates at 4 and `dst_out` emits 1..10 in order, one per cycle.
